// File: rtl/stream_serializer_pkg.sv
// stream_pkg: shared constants and types for the stream serializer slice.
//   DEF_T_DATA_WIDTH : default width of one lane
//   DEF_KEEP_WIDTH   : default number of input lanes
//   lane_t           : one lane of data
//   state_e          : serializer FSM states
//   sel_width()      : bits needed to index KEEP_WIDTH lanes
package stream_pkg;

  localparam int unsigned DEF_T_DATA_WIDTH = 4;
  localparam int unsigned DEF_KEEP_WIDTH   = 7;

  typedef logic [DEF_T_DATA_WIDTH-1:0] lane_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Index width for a lane select, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/stream_serializer_if.sv
// stream_serializer_if: wide-word ingress plus single-lane egress bundle.
//   s_data_i/s_keep_i/s_last_i/s_valid_i/s_ready_o : wide word stream in
//   m_data_o/m_last_o/m_valid_o/m_ready_i          : one lane per beat out
//   drop_last_o                                    : empty frame-end word dropped
// slave modport is the serializer's view; master is the surrounding logic's.
interface stream_serializer_if #(
  parameter int unsigned T_DATA_WIDTH = stream_pkg::DEF_T_DATA_WIDTH,
  parameter int unsigned KEEP_WIDTH   = stream_pkg::DEF_KEEP_WIDTH
);

  logic [T_DATA_WIDTH-1:0] s_data_i [KEEP_WIDTH];
  logic [KEEP_WIDTH-1:0]   s_keep_i;
  logic                    s_last_i;
  logic                    s_valid_i;
  logic                    s_ready_o;
  logic [T_DATA_WIDTH-1:0] m_data_o;
  logic                    m_last_o;
  logic                    m_valid_o;
  logic                    m_ready_i;
  logic                    drop_last_o;

  modport slave (
    input  s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_last_o, m_valid_o, drop_last_o
  );

  modport master (
    output s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_last_o, m_valid_o, drop_last_o
  );

endinterface

// File: rtl/stream_serializer_lane_priority_encoder.sv
// lane_priority_encoder: picks the lowest pending lane of a keep mask.
//   rem_i   : remaining-lane mask
//   sel_o   : index of the lowest set bit (0 when rem_i is empty)
//   final_o : exactly one bit of rem_i is set
//   clr_o   : one-hot mask of the selected lane
module lane_priority_encoder #(
  parameter int unsigned KEEP_WIDTH = stream_pkg::DEF_KEEP_WIDTH,
  parameter int unsigned SEL_WIDTH  = stream_pkg::sel_width(KEEP_WIDTH)
) (
  input  logic [KEEP_WIDTH-1:0] rem_i,
  output logic [SEL_WIDTH-1:0]  sel_o,
  output logic                  final_o,
  output logic [KEEP_WIDTH-1:0] clr_o
);

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    sel_o = '0;
    for (int i = int'(KEEP_WIDTH) - 1; i >= 0; i--) begin
      if (rem_i[i]) sel_o = SEL_WIDTH'(i);
    end
  end

  // Two's-complement trick isolates the lowest set bit.
  assign clr_o   = rem_i & (~rem_i + KEEP_WIDTH'(1));
  assign final_o = (rem_i != '0) && ((rem_i & (rem_i - KEEP_WIDTH'(1))) == '0);

endmodule

// File: rtl/stream_serializer.sv
// stream_serializer: emits the kept lanes of each wide word one per cycle,
// in ascending lane order, carrying the frame-end flag onto the last kept lane.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : slave view of stream_serializer_if (ingress word, egress lane,
//           drop_last_o pulse for a discarded keep=0 last=1 word)
module stream_serializer
  import stream_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = DEF_T_DATA_WIDTH,
  parameter int unsigned KEEP_WIDTH   = DEF_KEEP_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  stream_serializer_if.slave  bus
);

  localparam int unsigned SEL_WIDTH = sel_width(KEEP_WIDTH);

  state_e                  state_q, state_d;
  logic [T_DATA_WIDTH-1:0] data_q [KEEP_WIDTH];
  logic [T_DATA_WIDTH-1:0] data_d [KEEP_WIDTH];
  logic [KEEP_WIDTH-1:0]   rem_q, rem_d;
  logic                    last_q, last_d;
  logic                    drop_q, drop_d;
  logic                    s_ready_c;

  logic [SEL_WIDTH-1:0]    sel;
  logic                    is_final;
  logic [KEEP_WIDTH-1:0]   clr_mask;

  lane_priority_encoder #(
    .KEEP_WIDTH (KEEP_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_enc (
    .rem_i   (rem_q),
    .sel_o   (sel),
    .final_o (is_final),
    .clr_o   (clr_mask)
  );

  // State and holding register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      for (int i = 0; i < int'(KEEP_WIDTH); i++) data_q[i] <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
    end
  end

  // Next state: accept in IDLE, or chain the next word on the final lane handshake.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    rem_d     = rem_q;
    last_d    = last_q;
    drop_d    = 1'b0;
    s_ready_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        s_ready_c = 1'b1;
        if (bus.s_valid_i) begin
          if (bus.s_keep_i != '0) begin
            data_d  = bus.s_data_i;
            rem_d   = bus.s_keep_i;
            last_d  = bus.s_last_i;
            state_d = SHIFT;
          end else begin
            drop_d  = bus.s_last_i;
          end
        end
      end
      SHIFT: begin
        if (bus.m_ready_i) begin
          rem_d = rem_q & ~clr_mask;
          if (is_final) begin
            s_ready_c = 1'b1;
            state_d   = IDLE;
            if (bus.s_valid_i) begin
              if (bus.s_keep_i != '0) begin
                data_d  = bus.s_data_i;
                rem_d   = bus.s_keep_i;
                last_d  = bus.s_last_i;
                state_d = SHIFT;
              end else begin
                drop_d  = bus.s_last_i;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Egress is decoded from registers only; ready is held low during reset.
  assign bus.s_ready_o   = s_ready_c & ~rst_i;
  assign bus.m_valid_o   = (state_q == SHIFT);
  assign bus.m_data_o    = data_q[sel];
  assign bus.m_last_o    = (state_q == SHIFT) & is_final & last_q;
  assign bus.drop_last_o = drop_q;

endmodule

// File: tb/tb_stream_serializer.sv
// Directed bench for stream_serializer: reset, full/sparse words,
// backpressure, back-to-back chaining, empty last word, reset mid-word.
module tb_stream_serializer;
  import stream_pkg::*;

  localparam int unsigned TW = DEF_T_DATA_WIDTH;
  localparam int unsigned KW = DEF_KEEP_WIDTH;
  localparam int unsigned DW = TW * KW;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  stream_serializer_if sif ();

  stream_serializer dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (sif)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_word(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    for (int i = 0; i < int'(KW); i++) sif.s_data_i[i] = d[i*TW +: TW];
    sif.s_keep_i = k;
    sif.s_last_i = l;
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  // Collect n lanes; lane g expected at exp_d[g*TW +: TW]. With stall, ready toggles 1,0,1,...
  task automatic drain(input int n, input logic [DW-1:0] exp_d, input logic [KW-1:0] exp_last,
                       input logic [KW-1:0] exp_fin, input bit stall, input int exp_cyc);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 40) begin
      sif.m_ready_i = stall ? ((cyc % 2) == 0) : 1'b1;
      @(negedge clk_i);
      check_eq("lane_valid", 32'(sif.m_valid_o), 32'd1);
      check_eq("lane_data", 32'(sif.m_data_o), 32'(exp_d[got*TW +: TW]));
      check_eq("lane_last", 32'(sif.m_last_o), 32'(exp_last[got]));
      check_eq("lane_s_ready", 32'(sif.s_ready_o), 32'(exp_fin[got] & sif.m_ready_i));
      if (sif.m_valid_o && sif.m_ready_i) got++;
      step();
      cyc++;
    end
    check_eq("lane_count", 32'(got), 32'(n));
    check_eq("lane_cycles", 32'(cyc), 32'(exp_cyc));
    sif.m_ready_i = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.s_valid_i = 1'b0;
    sif.m_ready_i = 1'b1;
    load_word('0, '0, 1'b0);

    // Reset state
    #2;
    check_eq("rst_m_valid", 32'(sif.m_valid_o), 32'd0);
    check_eq("rst_m_last", 32'(sif.m_last_o), 32'd0);
    check_eq("rst_m_data", 32'(sif.m_data_o), 32'd0);
    check_eq("rst_drop", 32'(sif.drop_last_o), 32'd0);
    check_eq("rst_s_ready", 32'(sif.s_ready_o), 32'd0);
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("post_rst_s_ready", 32'(sif.s_ready_o), 32'd1);
    check_eq("post_rst_m_valid", 32'(sif.m_valid_o), 32'd0);
    step();

    // Full word, lanes 1..7, last=1
    load_word(28'h7654321, 7'h7F, 1'b1);
    sif.s_valid_i = 1'b1;
    @(negedge clk_i);
    check_eq("full_accept_ready", 32'(sif.s_ready_o), 32'd1);
    step();
    sif.s_valid_i = 1'b0;
    drain(7, 28'h7654321, 7'h40, 7'h40, 1'b0, 7);
    @(negedge clk_i);
    check_eq("full_done_valid", 32'(sif.m_valid_o), 32'd0);
    step();

    // Sparse word: lanes 1,4,6 = A,B,C, last=0
    load_word(28'hC0B00A0, 7'b1010010, 1'b0);
    sif.s_valid_i = 1'b1;
    step();
    sif.s_valid_i = 1'b0;
    drain(3, 28'h0000CBA, 7'h00, 7'b0000100, 1'b0, 3);
    @(negedge clk_i);
    check_eq("sparse_done_valid", 32'(sif.m_valid_o), 32'd0);
    step();

    // Backpressure: ready alternates, 7 lanes over 13 cycles
    load_word(28'h7654321, 7'h7F, 1'b1);
    sif.s_valid_i = 1'b1;
    step();
    sif.s_valid_i = 1'b0;
    drain(7, 28'h7654321, 7'h40, 7'h40, 1'b1, 13);
    @(negedge clk_i);
    check_eq("bp_done_valid", 32'(sif.m_valid_o), 32'd0);
    step();

    // Back-to-back: {1,2} then {5} with last, no bubble
    load_word(28'h0000021, 7'h03, 1'b0);
    sif.s_valid_i = 1'b1;
    @(negedge clk_i);
    check_eq("b2b_w1_ready", 32'(sif.s_ready_o), 32'd1);
    step();
    load_word(28'h0000005, 7'h01, 1'b1);
    @(negedge clk_i);
    check_eq("b2b_l0_valid", 32'(sif.m_valid_o), 32'd1);
    check_eq("b2b_l0_data", 32'(sif.m_data_o), 32'd1);
    check_eq("b2b_l0_last", 32'(sif.m_last_o), 32'd0);
    check_eq("b2b_l0_s_ready", 32'(sif.s_ready_o), 32'd0);
    step();
    @(negedge clk_i);
    check_eq("b2b_l1_valid", 32'(sif.m_valid_o), 32'd1);
    check_eq("b2b_l1_data", 32'(sif.m_data_o), 32'd2);
    check_eq("b2b_l1_last", 32'(sif.m_last_o), 32'd0);
    check_eq("b2b_l1_s_ready", 32'(sif.s_ready_o), 32'd1);
    step();
    sif.s_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("b2b_l2_valid", 32'(sif.m_valid_o), 32'd1);
    check_eq("b2b_l2_data", 32'(sif.m_data_o), 32'd5);
    check_eq("b2b_l2_last", 32'(sif.m_last_o), 32'd1);
    check_eq("b2b_l2_s_ready", 32'(sif.s_ready_o), 32'd1);
    step();
    @(negedge clk_i);
    check_eq("b2b_done_valid", 32'(sif.m_valid_o), 32'd0);
    step();

    // Empty last word in IDLE: dropped with a one-cycle pulse
    load_word('0, 7'h00, 1'b1);
    sif.s_valid_i = 1'b1;
    @(negedge clk_i);
    check_eq("empty_s_ready", 32'(sif.s_ready_o), 32'd1);
    check_eq("empty_drop_pre", 32'(sif.drop_last_o), 32'd0);
    step();
    sif.s_valid_i = 1'b0;
    sif.s_last_i  = 1'b0;
    @(negedge clk_i);
    check_eq("empty_drop_pulse", 32'(sif.drop_last_o), 32'd1);
    check_eq("empty_m_valid", 32'(sif.m_valid_o), 32'd0);
    check_eq("empty_s_ready_after", 32'(sif.s_ready_o), 32'd1);
    step();
    @(negedge clk_i);
    check_eq("empty_drop_clear", 32'(sif.drop_last_o), 32'd0);
    check_eq("empty_m_valid_after", 32'(sif.m_valid_o), 32'd0);
    step();

    // Reset mid-word after 3 lanes sent
    load_word(28'h7654321, 7'h7F, 1'b1);
    sif.s_valid_i = 1'b1;
    step();
    sif.s_valid_i = 1'b0;
    step();
    step();
    step();
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("midrst_m_valid", 32'(sif.m_valid_o), 32'd0);
    check_eq("midrst_s_ready", 32'(sif.s_ready_o), 32'd0);
    check_eq("midrst_m_last", 32'(sif.m_last_o), 32'd0);
    step();
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("midrst_rel_s_ready", 32'(sif.s_ready_o), 32'd1);
    for (int c = 0; c < 5; c++) begin
      check_eq("midrst_no_lane", 32'(sif.m_valid_o), 32'd0);
      @(negedge clk_i);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
